iot_tile_controller: RTL and testbench
======================================

Name: iot_tile_controller

Overview:
Parametrised successor of the single-tile IoT accelerator sequencer. Sequences multi-tile matrix jobs: for each weight tile it loads W_ROWS weight rows into the PE array, then streams num_vectors activations and writes num_vectors results. Base addresses are programmable, the PE latency is configurable, and the block supports abort, a sticky IRQ and a single-cycle done pulse. It sits between the AXI slave register file and the PE array / weight / activation / output SRAMs.

Parameters:
ADDR_WIDTH, 10, SRAM address width; all address arithmetic is modulo 2^ADDR_WIDTH.
CNT_WIDTH, 16, width of the vector count and internal counters.
TILE_WIDTH, 8, width of the tile count and tile index.
W_ROWS, 4, weight rows read per tile; must be at least 1.
PE_LATENCY, 5, cycles from an activation read strobe to its result being valid at the output SRAM; must be at least 1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; sampled only in IDLE
abort  in  1  terminate the current job; sampled in every non-IDLE state
clear_irq  in  1  clears irq
num_vectors  in  CNT_WIDTH  vectors per tile
num_tiles  in  TILE_WIDTH  tiles per job
w_base, act_base, out_base  in  ADDR_WIDTH each  SRAM base addresses
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
irq  out  1  sticky completion interrupt
aborted  out  1  sticky; last job was aborted
tile_idx  out  TILE_WIDTH  index of the current tile
pe_enable, pe_load_weight  out  1 each  PE array control
w_sram_addr / w_sram_re  out  ADDR_WIDTH / 1  weight SRAM read
act_sram_addr / act_sram_re  out  ADDR_WIDTH / 1  activation SRAM read
out_sram_addr / out_sram_we  out  ADDR_WIDTH / 1  output SRAM write
cycle_count  out  32  busy-cycle counter (see Optional Feature)

Behaviour:
- All outputs are registered. On reset, every output is 0 and the state is IDLE.
- States: IDLE, W_LOAD, W_SETTLE, COMPUTE, DONE.
- IDLE:
  - On start, latch num_vectors, num_tiles and the three base addresses; clear aborted; set busy=1.
  - If the latched num_vectors==0 or num_tiles==0, go to DONE. Otherwise set tile_idx=0 and out_ptr=0, then go to W_LOAD.
- W_LOAD (W_ROWS cycles):
  - Each cycle assert w_sram_re with w_sram_addr = w_base + tile_idx*W_ROWS + r, for r = 0..W_ROWS-1.
  - pe_load_weight is w_sram_re delayed by exactly 1 cycle (SRAM read latency 1).
  - After the last row, go to W_SETTLE.
- W_SETTLE: one cycle carrying the final pe_load_weight. Clear process_cnt and write_cnt, then go to COMPUTE.
- COMPUTE:
  - pe_enable=1 throughout.
  - While process_cnt < num_vectors: act_sram_re=1 and act_sram_addr = act_base + process_cnt. The first act_sram_re occurs the cycle after the last pe_load_weight.
  - While process_cnt >= PE_LATENCY and write_cnt < num_vectors: out_sram_we=1 and out_sram_addr = out_base + out_ptr; increment out_ptr and write_cnt. The first write occurs PE_LATENCY cycles after the first act_sram_re.
  - out_ptr runs continuously across tiles, so outputs are packed contiguously.
  - After the last write of a tile: if tile_idx+1 < num_tiles, increment tile_idx and go to W_LOAD (pe_enable drops to 0 during reload). Otherwise go to DONE.
  - Per-tile compute length is PE_LATENCY + num_vectors cycles.
- DONE (1 cycle): done=1, irq set, busy=0, pe_enable=0; return to IDLE.
- irq: sticky until clear_irq. If the set and clear_irq occur in the same cycle, set wins.
- start while busy: ignored.
- abort in any non-IDLE state:
  - Next cycle: all strobes, pe_enable and busy are 0, aborted=1, state is IDLE.
  - done and irq are not asserted.
  - Writes already issued are not retracted.
- Address overflow past 2^ADDR_WIDTH-1 wraps to 0; no error is raised.
- Reset asserted mid-job: immediate return to the reset values.

Optional Feature:
IOT_CTRL_PERF_CNT_EN:
- Defined: cycle_count clears on an accepted start, increments every cycle busy=1 (including the DONE entry cycle), and holds its value after the job ends or is aborted.
- Undefined: cycle_count is tied to 0 and no counter logic is generated. The port list is identical in both cases.

Test Plan:
1. Reset, defaults, num_tiles=1, num_vectors=3, w_base=0, act_base=0, out_base=512 -> w reads at addresses 0..3; pe_load_weight 4 cycles, each lagging its read by 1; act reads 0,1,2; writes 512,513,514, first 5 cycles after the first act read; one done pulse; irq=1 until clear_irq.
2. num_tiles=2, num_vectors=2, w_base=16, out_base=600 -> weight reads 16..19, then 20..23; writes 600,601, then 602,603; tile_idx 0->1; a single done pulse.
3. num_vectors=0, num_tiles=3 -> done pulse 2 cycles after start; no re/we strobe ever asserted; irq=1.
4. abort asserted on the 2nd write of a 4-vector job -> next cycle all strobes=0, busy=0, aborted=1, irq=0; a following start runs cleanly and clears aborted.
5. start pulsed mid-job, and clear_irq coincident with the DONE cycle -> the second start is ignored; irq=1 after DONE.
6. out_base=1022, num_vectors=4 (ADDR_WIDTH=10) -> write addresses 1022, 1023, 0, 1. With IOT_CTRL_PERF_CNT_EN defined, cycle_count equals the counted busy cycles.

Source files
------------

// File: rtl/iot_tile_controller.sv
// iot_tile_controller: sequences multi-tile matrix jobs for the IoT PE array.
// For each weight tile it reads W_ROWS weight rows into the PE array. It then
// streams num_vectors activations and writes num_vectors results. Output
// addresses are packed contiguously across tiles. All outputs are registered.
//
// Optional feature macro: IOT_CTRL_PERF_CNT_EN
//   defined   -> cycle_count counts busy cycles of the current/last job
//   undefined -> cycle_count is tied to 0 (port list unchanged)
//
// Control protocol: start is a single-cycle request that is only honoured in
// IDLE. A start that arrives while busy is dropped, and nothing is queued.
// abort is honoured in any non-IDLE state and takes effect on the next cycle.
module iot_tile_controller #(
   parameter int ADDR_WIDTH = 10,
   parameter int CNT_WIDTH  = 16,
   parameter int TILE_WIDTH = 8,
   parameter int W_ROWS     = 4,
   parameter int PE_LATENCY = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  clear_irq,
   input  logic [CNT_WIDTH-1:0]  num_vectors,
   input  logic [TILE_WIDTH-1:0] num_tiles,
   input  logic [ADDR_WIDTH-1:0] w_base,
   input  logic [ADDR_WIDTH-1:0] act_base,
   input  logic [ADDR_WIDTH-1:0] out_base,
   output logic                  busy,
   output logic                  done,
   output logic                  irq,
   output logic                  aborted,
   output logic [TILE_WIDTH-1:0] tile_idx,
   output logic                  pe_enable,
   output logic                  pe_load_weight,
   output logic [ADDR_WIDTH-1:0] w_sram_addr,
   output logic                  w_sram_re,
   output logic [ADDR_WIDTH-1:0] act_sram_addr,
   output logic                  act_sram_re,
   output logic [ADDR_WIDTH-1:0] out_sram_addr,
   output logic                  out_sram_we,
   output logic [31:0]           cycle_count
);

   localparam int RW = (W_ROWS > 1) ? $clog2(W_ROWS) : 1;
   localparam logic [RW-1:0]        LAST_ROW = RW'(W_ROWS - 1);
   localparam logic [CNT_WIDTH:0]   LAT      = (CNT_WIDTH + 1)'(PE_LATENCY);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_W_LOAD   = 3'd1,
      S_W_SETTLE = 3'd2,
      S_COMPUTE  = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   // FSM state register; kept as a named signal so checkers can bind to it
   state_t state;

   logic [CNT_WIDTH-1:0]  nv_l;
   logic [TILE_WIDTH-1:0] nt_l;
   logic [ADDR_WIDTH-1:0] act_base_l;
   logic [ADDR_WIDTH-1:0] out_base_l;
   logic [ADDR_WIDTH-1:0] out_ptr;
   logic [RW-1:0]         row;
   // process_cnt is the compute-cycle index within a tile; it spans
   // PE_LATENCY + num_vectors, so it carries one extra bit
   logic [CNT_WIDTH:0]    process_cnt;
   logic [CNT_WIDTH-1:0]  write_cnt;

   logic [CNT_WIDTH:0]    proc_nxt;
   logic [TILE_WIDTH:0]   tile_nxt;
   logic                  last_write;
   logic                  irq_set;

   assign proc_nxt   = process_cnt + (CNT_WIDTH + 1)'(1);
   assign tile_nxt   = {1'b0, tile_idx} + (TILE_WIDTH + 1)'(1);
   assign last_write = out_sram_we && (write_cnt == nv_l);
   // completion is recognised while sitting in DONE; an abort there cancels it
   assign irq_set    = (state == S_DONE) && !abort;

   // Main sequencer: state, strobes, addresses and job bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         aborted        <= 1'b0;
         tile_idx       <= '0;
         pe_enable      <= 1'b0;
         pe_load_weight <= 1'b0;
         w_sram_addr    <= '0;
         w_sram_re      <= 1'b0;
         act_sram_addr  <= '0;
         act_sram_re    <= 1'b0;
         out_sram_addr  <= '0;
         out_sram_we    <= 1'b0;
         nv_l           <= '0;
         nt_l           <= '0;
         act_base_l     <= '0;
         out_base_l     <= '0;
         out_ptr        <= '0;
         row            <= '0;
         process_cnt    <= '0;
         write_cnt      <= '0;
      end else if (state != S_IDLE && abort) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         aborted        <= 1'b1;
         pe_enable      <= 1'b0;
         pe_load_weight <= 1'b0;
         w_sram_re      <= 1'b0;
         act_sram_re    <= 1'b0;
         out_sram_we    <= 1'b0;
      end else begin
         done           <= 1'b0;
         // weight SRAM has one cycle of read latency
         pe_load_weight <= w_sram_re;
         case (state)
            S_IDLE: begin
               if (start) begin
                  nv_l       <= num_vectors;
                  nt_l       <= num_tiles;
                  act_base_l <= act_base;
                  out_base_l <= out_base;
                  aborted    <= 1'b0;
                  busy       <= 1'b1;
                  if (num_vectors == '0 || num_tiles == '0) begin
                     state <= S_DONE;
                  end else begin
                     tile_idx    <= '0;
                     out_ptr     <= '0;
                     row         <= '0;
                     w_sram_re   <= 1'b1;
                     w_sram_addr <= w_base;
                     state       <= S_W_LOAD;
                  end
               end
            end
            S_W_LOAD: begin
               if (row == LAST_ROW) begin
                  w_sram_re <= 1'b0;
                  state     <= S_W_SETTLE;
               end else begin
                  row         <= row + RW'(1);
                  w_sram_addr <= w_sram_addr + ADDR_WIDTH'(1);
               end
            end
            S_W_SETTLE: begin
               process_cnt   <= '0;
               write_cnt     <= '0;
               pe_enable     <= 1'b1;
               act_sram_re   <= 1'b1;
               act_sram_addr <= act_base_l;
               state         <= S_COMPUTE;
            end
            S_COMPUTE: begin
               if (last_write) begin
                  out_sram_we <= 1'b0;
                  act_sram_re <= 1'b0;
                  pe_enable   <= 1'b0;
                  if (tile_nxt < {1'b0, nt_l}) begin
                     // weight addresses continue where the previous tile stopped
                     tile_idx    <= tile_nxt[TILE_WIDTH-1:0];
                     row         <= '0;
                     w_sram_re   <= 1'b1;
                     w_sram_addr <= w_sram_addr + ADDR_WIDTH'(1);
                     state       <= S_W_LOAD;
                  end else begin
                     state <= S_DONE;
                  end
               end else begin
                  process_cnt   <= proc_nxt;
                  act_sram_re   <= (proc_nxt < {1'b0, nv_l});
                  act_sram_addr <= act_base_l + ADDR_WIDTH'(proc_nxt);
                  if (proc_nxt >= LAT && write_cnt < nv_l) begin
                     out_sram_we   <= 1'b1;
                     out_sram_addr <= out_base_l + out_ptr;
                     out_ptr       <= out_ptr + ADDR_WIDTH'(1);
                     write_cnt     <= write_cnt + CNT_WIDTH'(1);
                  end else begin
                     out_sram_we <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky interrupt. The completion event spans the DONE state and the
   // visible done pulse, and a clear in either cycle loses to the set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq <= 1'b0;
      end else if (irq_set) begin
         irq <= 1'b1;
      end else if (clear_irq && !done) begin
         irq <= 1'b0;
      end
   end

`ifdef IOT_CTRL_PERF_CNT_EN
   // Busy-cycle counter: restarts on an accepted start, holds once idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_count <= '0;
      end else if (state == S_IDLE && start) begin
         cycle_count <= '0;
      end else if (busy) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_iot_tile_controller.sv
// Testbench for iot_tile_controller. The reference model is a closed-form job
// schedule. Tile t starts its weight load at cycle 1 + t*(W_ROWS+1+LAT+nv)
// after the start edge. Every strobe, address and status bit is derived from
// that schedule cycle by cycle.
module tb_iot_tile_controller;

   localparam int AW   = 10;
   localparam int CW   = 16;
   localparam int TW   = 8;
   localparam int WR   = 4;
   localparam int LAT  = 5;
   localparam int AMOD = 1 << AW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          clear_irq;
   logic [CW-1:0] num_vectors;
   logic [TW-1:0] num_tiles;
   logic [AW-1:0] w_base;
   logic [AW-1:0] act_base;
   logic [AW-1:0] out_base;
   logic          busy;
   logic          done;
   logic          irq;
   logic          aborted;
   logic [TW-1:0] tile_idx;
   logic          pe_enable;
   logic          pe_load_weight;
   logic [AW-1:0] w_sram_addr;
   logic          w_sram_re;
   logic [AW-1:0] act_sram_addr;
   logic          act_sram_re;
   logic [AW-1:0] out_sram_addr;
   logic          out_sram_we;
   logic [31:0]   cycle_count;

   int checks;
   int errors;

   // current job as seen by the model
   int j_wb, j_ab, j_ob, j_nv, j_nt;
   int model_busy_cycles;
   logic [AW-1:0] wr_log[$];
   logic [AW-1:0] exp_q[$];

   typedef struct {
      bit busy, done, pe_en, pe_lw, w_re, a_re, o_we, tile_valid;
      int w_addr, a_addr, o_addr, tile;
   } exp_t;

   iot_tile_controller #(
      .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TILE_WIDTH(TW), .W_ROWS(WR), .PE_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .clear_irq(clear_irq),
      .num_vectors(num_vectors), .num_tiles(num_tiles),
      .w_base(w_base), .act_base(act_base), .out_base(out_base),
      .busy(busy), .done(done), .irq(irq), .aborted(aborted), .tile_idx(tile_idx),
      .pe_enable(pe_enable), .pe_load_weight(pe_load_weight),
      .w_sram_addr(w_sram_addr), .w_sram_re(w_sram_re),
      .act_sram_addr(act_sram_addr), .act_sram_re(act_sram_re),
      .out_sram_addr(out_sram_addr), .out_sram_we(out_sram_we),
      .cycle_count(cycle_count)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int job_total();
      if (j_nv == 0 || j_nt == 0) return 0;
      return j_nt * (WR + 1 + LAT + j_nv);
   endfunction

   // expected outputs in cycle n (n=1 is the cycle after the start edge)
   function automatic exp_t model(int n);
      exp_t e;
      int period, total, k, t, p, c;
      e = '{default:0};
      total  = job_total();
      period = WR + 1 + LAT + j_nv;
      if (n >= 1 && n <= total) begin
         e.busy = 1;
         k = n - 1;
         t = k / period;
         p = k % period;
         e.tile = t;
         e.tile_valid = 1;
         if (p < WR) begin
            e.w_re = 1;
            e.w_addr = (j_wb + t * WR + p) % AMOD;
         end
         if (p >= 1 && p <= WR) e.pe_lw = 1;
         if (p >= WR + 1) begin
            e.pe_en = 1;
            c = p - WR - 1;
            if (c < j_nv) begin
               e.a_re = 1;
               e.a_addr = (j_ab + c) % AMOD;
            end
            if (c >= LAT) begin
               e.o_we = 1;
               e.o_addr = (j_ob + t * j_nv + c - LAT) % AMOD;
            end
         end
      end else if (n == total + 1) begin
         e.busy = 1;
      end else if (n == total + 2) begin
         e.done = 1;
      end
      return e;
   endfunction

   // driver: run one job and check every cycle against the model.
   // abort_at / clr_at / restart_at are cycle numbers (0 = unused)
   task automatic run_job(input int wb, input int ab, input int ob, input int nv, input int nt,
                          input int abort_at, input int clr_at, input int restart_at);
      exp_t e;
      int last, done_n;
      bit exp_ab, exp_irq;
      j_wb = wb; j_ab = ab; j_ob = ob; j_nv = nv; j_nt = nt;
      wr_log.delete();
      model_busy_cycles = 0;
      done_n = job_total() + 2;
      last = (abort_at > 0) ? abort_at + 3 : done_n + 1;
      @(negedge clk);
      num_vectors = CW'(nv); num_tiles = TW'(nt);
      w_base = AW'(wb); act_base = AW'(ab); out_base = AW'(ob);
      start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         e = model(n);
         if (abort_at > 0 && n > abort_at) e = '{default:0};
         exp_ab  = (abort_at > 0 && n > abort_at);
         exp_irq = (abort_at == 0 && n >= done_n);
         if (e.busy) model_busy_cycles++;
         if (out_sram_we) wr_log.push_back(out_sram_addr);
         checks++; if (busy !== e.busy) begin errors++; $display("FAIL busy n=%0d got=%b exp=%b", n, busy, e.busy); end
         checks++; if (done !== e.done) begin errors++; $display("FAIL done n=%0d got=%b exp=%b", n, done, e.done); end
         checks++; if (pe_enable !== e.pe_en) begin errors++; $display("FAIL pe_enable n=%0d got=%b exp=%b", n, pe_enable, e.pe_en); end
         checks++; if (pe_load_weight !== e.pe_lw) begin errors++; $display("FAIL pe_load_weight n=%0d got=%b exp=%b", n, pe_load_weight, e.pe_lw); end
         checks++; if (w_sram_re !== e.w_re) begin errors++; $display("FAIL w_sram_re n=%0d got=%b exp=%b", n, w_sram_re, e.w_re); end
         checks++; if (act_sram_re !== e.a_re) begin errors++; $display("FAIL act_sram_re n=%0d got=%b exp=%b", n, act_sram_re, e.a_re); end
         checks++; if (out_sram_we !== e.o_we) begin errors++; $display("FAIL out_sram_we n=%0d got=%b exp=%b", n, out_sram_we, e.o_we); end
         checks++; if (aborted !== exp_ab) begin errors++; $display("FAIL aborted n=%0d got=%b exp=%b", n, aborted, exp_ab); end
         checks++; if (irq !== exp_irq) begin errors++; $display("FAIL irq n=%0d got=%b exp=%b", n, irq, exp_irq); end
         if (e.w_re) begin
            checks++; if (w_sram_addr !== AW'(e.w_addr)) begin errors++; $display("FAIL w_sram_addr n=%0d got=%0d exp=%0d", n, w_sram_addr, e.w_addr); end
         end
         if (e.a_re) begin
            checks++; if (act_sram_addr !== AW'(e.a_addr)) begin errors++; $display("FAIL act_sram_addr n=%0d got=%0d exp=%0d", n, act_sram_addr, e.a_addr); end
         end
         if (e.o_we) begin
            checks++; if (out_sram_addr !== AW'(e.o_addr)) begin errors++; $display("FAIL out_sram_addr n=%0d got=%0d exp=%0d", n, out_sram_addr, e.o_addr); end
         end
         if (e.tile_valid) begin
            checks++; if (tile_idx !== TW'(e.tile)) begin errors++; $display("FAIL tile_idx n=%0d got=%0d exp=%0d", n, tile_idx, e.tile); end
         end
         // drive inputs for this cycle; config inputs are scrambled to prove latching
         start       = (n == restart_at);
         abort       = (n == abort_at);
         clear_irq   = (clr_at > 0 && (n == clr_at || n == clr_at + 1));
         num_vectors = CW'($urandom_range(0, 9));
         num_tiles   = TW'($urandom_range(0, 4));
         w_base      = AW'($urandom_range(0, AMOD - 1));
         act_base    = AW'($urandom_range(0, AMOD - 1));
         out_base    = AW'($urandom_range(0, AMOD - 1));
      end
      start = 1'b0; abort = 1'b0; clear_irq = 1'b0;
`ifdef IOT_CTRL_PERF_CNT_EN
      checks++; if (cycle_count !== 32'(model_busy_cycles)) begin errors++; $display("FAIL cycle_count got=%0d exp=%0d", cycle_count, model_busy_cycles); end
`else
      checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL cycle_count got=%0d exp=0", cycle_count); end
`endif
   endtask

   task automatic clear_irq_pulse();
      @(negedge clk);
      clear_irq = 1'b1;
      @(negedge clk);
      clear_irq = 1'b0;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
   endtask

   task automatic check_wr_log(input string name);
      checks++;
      if (wr_log.size() != exp_q.size()) begin
         errors++; $display("FAIL %s write_count got=%0d exp=%0d", name, wr_log.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (wr_log[i] !== exp_q[i]) begin
               errors++; $display("FAIL %s write[%0d] got=%0d exp=%0d", name, i, wr_log[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; clear_irq = 1'b0;
      num_vectors = '0; num_tiles = '0; w_base = '0; act_base = '0; out_base = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, irq, aborted, pe_enable, pe_load_weight, w_sram_re, act_sram_re, out_sram_we} !== 9'b0 ||
          tile_idx !== '0 || w_sram_addr !== '0 || act_sram_addr !== '0 || out_sram_addr !== '0 || cycle_count !== 32'd0) begin
         errors++; $display("FAIL reset_outputs got busy=%b done=%b irq=%b tile=%0d exp all zero", busy, done, irq, tile_idx);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_tile();
      run_job(0, 0, 512, 3, 1, 0, 0, 0);
      exp_q = '{10'd512, 10'd513, 10'd514};
      check_wr_log("single_tile");
      clear_irq_pulse();
   endtask

   task automatic test_multi_tile();
      run_job(16, 40, 600, 2, 2, 0, 0, 0);
      exp_q = '{10'd600, 10'd601, 10'd602, 10'd603};
      check_wr_log("multi_tile");
      clear_irq_pulse();
   endtask

   task automatic test_zero_vectors();
      run_job(5, 6, 7, 0, 3, 0, 0, 0);
      checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL zero_vectors writes got=%0d exp=0", wr_log.size()); end
      clear_irq_pulse();
   endtask

   task automatic test_abort();
      // second write of a 4-vector single-tile job lands in cycle WR+LAT+3
      run_job(100, 200, 300, 4, 1, WR + LAT + 3, 0, 0);
      exp_q = '{10'd300, 10'd301};
      check_wr_log("abort");
      run_job(8, 9, 10, 2, 1, 0, 0, 0);
      clear_irq_pulse();
   endtask

   task automatic test_start_while_busy();
      int total;
      j_nv = 3; j_nt = 2;
      total = job_total();
      run_job(50, 60, 70, 3, 2, 0, total + 1, 3);
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b exp=1", irq); end
      clear_irq_pulse();
   endtask

   task automatic test_addr_wrap();
      run_job(1022, 1021, 1022, 4, 1, 0, 0, 0);
      exp_q = '{10'd1022, 10'd1023, 10'd0, 10'd1};
      check_wr_log("addr_wrap");
      clear_irq_pulse();
   endtask

   task automatic test_random_jobs();
      for (int i = 0; i < 12; i++) begin
         run_job($urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
                 $urandom_range(0, 6), $urandom_range(0, 3), 0, 0, 0);
         clear_irq_pulse();
      end
   endtask

   task automatic test_reset_mid_job();
      @(negedge clk);
      num_vectors = CW'(3); num_tiles = TW'(2);
      w_base = AW'(1); act_base = AW'(2); out_base = AW'(3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, irq, aborted, pe_enable, pe_load_weight, w_sram_re, act_sram_re, out_sram_we} !== 9'b0 ||
          tile_idx !== '0 || cycle_count !== 32'd0) begin
         errors++; $display("FAIL reset_mid_job got busy=%b pe_enable=%b act_re=%b exp all zero", busy, pe_enable, act_sram_re);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_tile();
      test_multi_tile();
      test_zero_vectors();
      test_abort();
      test_start_while_busy();
      test_addr_wrap();
      test_random_jobs();
      test_reset_mid_job();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
